// File: rtl/imem_loader.sv
// Program loader: receives a little-endian word count and instruction words over a
// byte valid/ready stream and writes them into IMEM, holding the core while loading.
module imem_loader #(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned IMEM_DEPTH = 1024,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [PC_WIDTH-1:0]   wr_addr,
  output logic [INST_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam logic [31:0] MAX_WORDS = 32'((IMEM_DEPTH - BASE_ADDR) / 4);

  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, DONE, ERR} state_t;

  state_t      state, state_next;
  logic [1:0]  byte_cnt;
  logic [31:0] word_idx;
  logic [31:0] len_reg;
  logic [23:0] shift;
  logic [31:0] len_full;
  logic        accept;
  logic        idle_like;

  assign accept    = in_valid && in_ready;
  assign idle_like = (state == IDLE) || (state == DONE) || (state == ERR);
  // Length bytes and instruction bytes share one shift register; the 4th byte completes the value.
  assign len_full  = {in_data, shift};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE, ERR: if (start) state_next = LEN;
      LEN: begin
        if (accept && byte_cnt == 2'd3) begin
          if (len_full == '0)            state_next = DONE;
          else if (len_full > MAX_WORDS) state_next = ERR;
          else                           state_next = DATA;
        end
      end
      DATA:  if (accept && byte_cnt == 2'd3) state_next = WRITE;
      WRITE: state_next = (word_idx + 32'd1 == len_reg) ? DONE : DATA;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    wr_en    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    unique case (state)
      LEN, DATA: begin in_ready = 1'b1; busy = 1'b1; end
      WRITE:     begin wr_en = 1'b1; busy = 1'b1; end
      DONE:      done  = 1'b1;
      ERR:       error = 1'b1;
      default:   ;
    endcase
    cpu_hold = busy;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt <= '0;
      word_idx <= '0;
      len_reg  <= '0;
      shift    <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else if (start && idle_like) begin
      byte_cnt <= '0;
      word_idx <= '0;
      shift    <= '0;
    end else begin
      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        shift    <= {in_data, shift[23:8]};
        if (state == LEN && byte_cnt == 2'd3) len_reg <= len_full;
        if (state == DATA && byte_cnt == 2'd3) begin
          wr_data <= INST_WIDTH'({in_data, shift});
          wr_addr <= PC_WIDTH'(BASE_ADDR) + PC_WIDTH'({word_idx, 2'b00});
        end
      end
      if (state == WRITE) word_idx <= word_idx + 32'd1;
    end
  end

endmodule
